// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Brief    : Loadable down-counter / interval timer with one-cycle terminal
//            pulse and optional auto-reload for periodic ticks.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] v,
    input  logic             reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_ZERO = '0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] rv_q;
    logic             tc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= C_ZERO;
            rv_q    <= C_ZERO;
            tc_q    <= 1'b0;
        end else if (ld) begin
            // A load restarts the timer and cancels any terminal event due now.
            count_q <= v;
            rv_q    <= v;
            tc_q    <= 1'b0;
            state_q <= (v != C_ZERO) ? RUN : IDLE;
        end else if (state_q == RUN && en) begin
            if (count_q == C_ONE) begin
                tc_q <= 1'b1;
                if (reload) begin
                    count_q <= rv_q;
                end else begin
                    count_q <= C_ZERO;
                    state_q <= IDLE;
                end
            end else begin
                count_q <= count_q - C_ONE;
                tc_q    <= 1'b0;
            end
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer
// Brief    : Self-checking bench for countdown_timer: elapsed-cycle model plus
//            directed vectors with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic             ld;
    logic [WIDTH-1:0] v;
    logic             reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;

    int total;
    int bad;
    bit chk_on;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .ld     (ld),
        .v      (v),
        .reload (reload),
        .count  (count),
        .tc     (tc),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: L = loaded period, n = enabled cycles elapsed in the current period.
    int m_L;
    int m_n;
    bit m_run;
    bit m_tc;

    always @(posedge clk) begin
        int L, n;
        bit run, t;
        L = m_L; n = m_n; run = m_run; t = 1'b0;
        if (rst) begin
            L = 0; n = 0; run = 1'b0;
        end else if (ld) begin
            L = int'(v); n = 0; run = (v != 0);
        end else if (run && en) begin
            n = n + 1;
            if (n == L) begin
                t = 1'b1;
                n = 0;
                if (!reload) run = 1'b0;
            end
        end
        m_L   <= L;
        m_n   <= n;
        m_run <= run;
        m_tc  <= t;
    end

    always @(negedge clk) begin
        int exp_count;
        if (chk_on) begin
            exp_count = m_run ? (m_L - m_n) : 0;
            total++;
            if (int'(count) != exp_count || tc != m_tc || busy != m_run) begin
                bad++;
                $display("FAIL model t=%0t count=%0d tc=%0b busy=%0b required count=%0d tc=%0b busy=%0b",
                         $time, count, tc, busy, exp_count, m_tc, m_run);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic chk3(input string name, input int c, input bit t, input bit b);
        chk({name, ".count"}, int'(count), c);
        chk({name, ".tc"},    int'(tc),    int'(t));
        chk({name, ".busy"},  int'(busy),  int'(b));
    endtask

    // Drive one cycle: inputs applied at a falling edge, return at the next one.
    task automatic cyc(input bit r, input bit l, input int val, input bit e, input bit rl);
        rst = r; ld = l; v = WIDTH'(val); en = e; reload = rl;
        @(negedge clk);
    endtask

    initial begin
        int exp_c[];
        int exp_t[];
        int pat[];

        total = 0; bad = 0; chk_on = 1'b0;
        rst = 1'b1; ld = 1'b0; en = 1'b0; v = '0; reload = 1'b0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        chk_on = 1'b1;
        chk3("reset", 0, 0, 0);

        // Reset overrides a simultaneous load and enable.
        cyc(0, 1, 9, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk3("mid", 7, 0, 1);
        cyc(1, 1, 5, 1, 0);
        chk3("rst_ovr", 0, 0, 0);

        // One-shot from 5.
        exp_c = '{5, 4, 3, 2, 1, 0, 0, 0};
        exp_t = '{0, 0, 0, 0, 0, 1, 0, 0};
        cyc(0, 1, 5, 0, 0);
        chk3("oneshot0", exp_c[0], 1'(exp_t[0]), 1);
        for (int i = 1; i < 8; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk3($sformatf("oneshot%0d", i), exp_c[i], 1'(exp_t[i]), exp_c[i] != 0);
        end

        // Auto-reload period 3.
        exp_c = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
        exp_t = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        cyc(0, 1, 3, 1, 1);
        chk3("reload0", exp_c[0], 1'(exp_t[0]), 1);
        for (int i = 1; i < 10; i++) begin
            cyc(0, 0, 0, 1, 1);
            chk3($sformatf("reload%0d", i), exp_c[i], 1'(exp_t[i]), 1);
        end

        // Enable gaps pause without losing the terminal event.
        pat   = '{1, 0, 0, 1, 1, 0, 1};
        exp_c = '{3, 3, 3, 2, 1, 1, 0};
        cyc(0, 1, 4, 0, 0);
        chk3("pause0", 4, 0, 1);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 1'(pat[i]), 0);
            chk3($sformatf("pause%0d", i + 1), exp_c[i], i == 6, exp_c[i] != 0);
        end

        // Load collides with a due terminal event.
        cyc(0, 1, 2, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk3("coll_pre", 1, 0, 1);
        cyc(0, 1, 7, 1, 0);
        chk3("coll_ld7", 7, 0, 1);
        cyc(0, 1, 0, 1, 0);
        chk3("coll_ld0", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk3("idle_en", 0, 0, 0);
        end

        // Period of one: tc every enabled cycle.
        cyc(0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 1);
            chk3("rv1", 1, 1, 1);
        end

        // Reload is sampled only at the terminal cycle.
        cyc(0, 1, 3, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        chk3("late_reload", 3, 1, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        chk3("late_oneshot", 0, 1, 0);

        // Full-scale load.
        cyc(0, 1, 255, 0, 0);
        chk3("max0", 255, 0, 1);
        for (int i = 1; i < 255; i++) begin
            cyc(0, 0, 0, 1, 0);
            if (tc) chk("max_early_tc", int'(tc), 0);
        end
        chk3("max254", 1, 0, 1);
        cyc(0, 0, 0, 1, 0);
        chk3("max255", 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk3("max_nowrap", 0, 0, 0);
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter and interval timer. The count direction is the opposite of the lab up-counter.
- Software/testbench loads a start value. The block decrements once per enabled cycle and emits a one-cycle terminal-count pulse on reaching the end.
- Optional auto-reload mode gives a periodic tick generator. This replaces hand-rolled clock-divider logic in later lab tasks (display refresh, prescalers).

Parameters:
- WIDTH, 8, bit width of count and load value.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- en  input  1  count enable; one decrement per cycle with en=1 while running
- ld  input  1  load strobe; captures v as start and reload value
- v  input  WIDTH  load value
- reload  input  1  mode: 1 = auto-reload at terminal count, 0 = one-shot
- count  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse, high for exactly one cycle (registered)
- busy  output  1  1 while timer is running (registered)

Behaviour:
- Reset:
  - rst=1 at posedge: count=0, tc=0, busy=0, internal reload register rv=0.
  - Reset overrides ld and en in the same cycle.
- States: IDLE (busy=0) and RUN (busy=1). busy is the state bit.
- Priority at each posedge: rst > ld > en-decrement > hold.
- Load (ld=1, rst=0), in either state:
  - count<=v, rv<=v, tc<=0.
  - busy<=1 if v!=0, else busy<=0.
  - en is ignored in a load cycle, so no decrement happens.
  - Load during RUN restarts the timer; any terminal event due that cycle is cancelled (tc stays 0).
- IDLE:
  - en has no effect; count holds, tc<=0.
  - No underflow: count never wraps below 0.
- RUN, en=1, count>1: count<=count-1, tc<=0.
- RUN, en=1, count==1 (terminal event):
  - tc<=1 for the following cycle only.
  - reload=1: count<=rv, busy stays 1. In this mode count never shows 0, and the period is exactly rv enabled cycles.
  - reload=0: count<=0, busy<=0 (go IDLE).
  - reload is sampled only in the terminal cycle; changing it mid-run affects only the next terminal event.
- RUN, en=0: count holds, tc<=0 (pause). A gap in en stretches the period but never drops or duplicates a tick.
- tc pulse timing:
  - Never asserted for two consecutive cycles, except reload with rv=1 and en held high, which gives a tc on every cycle.
  - In one-shot mode tc rises in the same cycle count first reads 0.
- Width rules:
  - Decrement is modulo-free because count>=1 whenever it decrements.
  - v = all-ones (255 for WIDTH=8) is legal and gives 255 enabled cycles to terminal.
- Outputs are pure registers; no combinational path from inputs to outputs.

Test Plan:
- Reset: drive count to a mid value, assert rst with ld=1 and en=1 in the same cycle -> next cycle count=0, busy=0, tc=0.
- One-shot: ld=1 with v=5, reload=0, then en=1 continuously -> count reads 5,4,3,2,1,0 on consecutive cycles. tc=1 only in the cycle count=0 first appears; busy falls in that cycle. Further en leaves count=0, tc=0.
- Auto-reload: ld with v=3, reload=1, en=1 for 10 cycles -> count 3,2,1,3,2,1,3,2,1,3. tc high exactly in the cycles count returns to 3 (every 3rd cycle); busy stays 1.
- Pause and gaps: ld with v=4, then en pattern 1,0,0,1,1,0,1 -> count 4,3,3,3,2,1,1,0. tc=1 only when 0 appears.
- Load collisions:
  - With count=1, RUN, en=1, assert ld with v=7 -> count=7, tc=0, busy=1.
  - ld with v=0 -> count=0, busy=0, no tc; subsequent en has no effect.
- Boundary width: WIDTH=8, ld with v=255, reload=0, en=1 -> tc asserts exactly 255 cycles after load, count=0 at that point, no wrap to 255 afterwards.
